// File: rtl/h6_mul_sequencer.sv
// H6 multiply sequencer: steps the H6 datapath through clear, load, N_ITER
// shift/add iterations and a two-register writeback, with abort and reject.
module h6_mul_sequencer #(
   parameter int unsigned N_ITER = 16
) (
   input  logic       CLK,
   input  logic       CLR,
   input  logic       start,
   input  logic       abort,
   input  logic [2:0] dst,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic       Rst_H6,
   output logic       MUL1,
   output logic       MUL2_1,
   output logic       MUL2_2,
   output logic       inQLK,
   output logic       inTWO,
   output logic       inTHREE,
   output logic       inFOUR,
   output logic       ALS_H6_a,
   output logic       ALS_H6_q,
   output logic [7:0] SR
);

   // One spare bit so the post-increment value N_ITER never wraps
   localparam int unsigned CW = $clog2(N_ITER) + 1;

   typedef enum logic [3:0] {
      IDLE, CLEAR, LOAD, STEP2, STEP3, STEP4, WB_Q, WB_A, DONE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    dst_q, dst_d;
   logic          err_q, err_d;

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dst_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dst_q   <= dst_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dst_d   = dst_q;
      err_d   = 1'b0;
      if (state_q == IDLE) begin
         // abort outranks start; R4/R5 targets are refused with a one-cycle err
         if (start && !abort) begin
            if (dst == 3'd4 || dst == 3'd5) begin
               err_d = 1'b1;
            end else begin
               dst_d   = dst;
               state_d = CLEAR;
            end
         end
      end else if (abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            CLEAR: begin
               cnt_d   = '0;
               state_d = LOAD;
            end
            LOAD:  state_d = STEP2;
            STEP2: state_d = STEP3;
            STEP3: state_d = STEP4;
            STEP4: begin
               cnt_d   = cnt_q + CW'(1);
               state_d = (cnt_q == CW'(N_ITER - 1)) ? WB_Q : STEP2;
            end
            WB_Q:  state_d = WB_A;
            WB_A:  state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      busy     = (state_q != IDLE);
      done     = 1'b0;
      err      = err_q;
      Rst_H6   = 1'b0;
      MUL1     = 1'b0;
      MUL2_1   = 1'b0;
      MUL2_2   = 1'b0;
      inQLK    = 1'b0;
      inTWO    = 1'b0;
      inTHREE  = 1'b0;
      inFOUR   = 1'b0;
      ALS_H6_a = 1'b0;
      ALS_H6_q = 1'b0;
      SR       = '0;
      case (state_q)
         CLEAR: Rst_H6 = 1'b1;
         LOAD: begin
            MUL1   = 1'b1;
            MUL2_1 = 1'b1;
            inQLK  = 1'b1;
         end
         STEP2: inTWO   = 1'b1;
         STEP3: inTHREE = 1'b1;
         STEP4: inFOUR  = 1'b1;
         WB_Q: begin
            ALS_H6_q = 1'b1;
            SR       = 8'b0000_0001 << dst_q;
         end
         WB_A: begin
            ALS_H6_a = 1'b1;
            SR       = 8'b0000_0001 << (dst_q + 3'd1);
         end
         DONE: done = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_h6_mul_sequencer.sv
// Directed bench for h6_mul_sequencer: full runs, wrap, reject, abort,
// async reset mid-operation and ignored starts while busy.
module tb_h6_mul_sequencer;

   localparam int unsigned NI = 16;
   localparam int unsigned LAST = 3 * NI + 5;

   logic       CLK = 1'b0;
   logic       CLR = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic [2:0] dst = '0;
   logic       busy, done, err, Rst_H6, MUL1, MUL2_1, MUL2_2, inQLK;
   logic       inTWO, inTHREE, inFOUR, ALS_H6_a, ALS_H6_q;
   logic [7:0] SR;

   int n_vec  = 0;
   int n_miss = 0;

   h6_mul_sequencer #(.N_ITER(NI)) dut (
      .CLK(CLK), .CLR(CLR), .start(start), .abort(abort), .dst(dst),
      .busy(busy), .done(done), .err(err), .Rst_H6(Rst_H6), .MUL1(MUL1),
      .MUL2_1(MUL2_1), .MUL2_2(MUL2_2), .inQLK(inQLK), .inTWO(inTWO),
      .inTHREE(inTHREE), .inFOUR(inFOUR), .ALS_H6_a(ALS_H6_a),
      .ALS_H6_q(ALS_H6_q), .SR(SR)
   );

   always #5 CLK = ~CLK;

   // {busy,done,err,Rst,MUL1,MUL2_1,MUL2_2,inQLK,inTWO,inTHREE,inFOUR,ALS_a,ALS_q,SR}
   logic [20:0] obs;
   assign obs = {busy, done, err, Rst_H6, MUL1, MUL2_1, MUL2_2, inQLK,
                 inTWO, inTHREE, inFOUR, ALS_H6_a, ALS_H6_q, SR};

   task automatic chk(input string tag, input logic [20:0] got, input logic [20:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected outputs in cycle c of an operation whose start was sampled at edge 0
   function automatic logic [20:0] exp_vec(input int c, input logic [2:0] d);
      logic [20:0] v;
      logic [7:0]  one;
      logic [2:0]  d1;
      v   = '0;
      one = 8'h01;
      d1  = d + 3'd1;
      if (c == 1) begin
         v[20] = 1'b1; v[17] = 1'b1;
      end else if (c == 2) begin
         v[20] = 1'b1; v[16] = 1'b1; v[15] = 1'b1; v[13] = 1'b1;
      end else if (c >= 3 && c <= 3 * NI + 2) begin
         v[20] = 1'b1;
         case ((c - 3) % 3)
            0: v[12] = 1'b1;
            1: v[11] = 1'b1;
            default: v[10] = 1'b1;
         endcase
      end else if (c == 3 * NI + 3) begin
         v[20] = 1'b1; v[8] = 1'b1; v[7:0] = one << d;
      end else if (c == 3 * NI + 4) begin
         v[20] = 1'b1; v[9] = 1'b1; v[7:0] = one << d1;
      end else if (c == LAST) begin
         v[20] = 1'b1; v[19] = 1'b1;
      end
      return v;
   endfunction

   // Full operation; dst is scrambled after acceptance, optional starts while busy
   task automatic run_op(input string tag, input logic [2:0] d, input bit busy_starts);
      dst   = d;
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      dst   = d ^ 3'b101;
      for (int c = 1; c <= LAST + 3; c++) begin
         chk($sformatf("%s_c%0d", tag, c), obs, exp_vec(c, d));
         start = busy_starts && c >= 5 && c <= 50;
         @(posedge CLK); #1;
      end
      start = 1'b0;
   endtask

   task automatic reject(input logic [2:0] d);
      dst   = d;
      start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      chk($sformatf("rej%0d_err", d), obs, 21'h040000);
      @(posedge CLK); #1;
      chk($sformatf("rej%0d_after", d), obs, '0);
   endtask

   initial begin
      #2;
      chk("reset", obs, '0);
      #11 CLR = 1'b1;

      run_op("basic", 3'd2, 1'b0);
      run_op("wrap", 3'd7, 1'b0);
      reject(3'd4);
      reject(3'd5);

      // abort together with start in IDLE: stays idle, no err
      dst = 3'd1; start = 1'b1; abort = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0; abort = 1'b0;
      chk("abort_start_c1", obs, '0);
      @(posedge CLK); #1;
      chk("abort_start_c2", obs, '0);

      // abort sampled at edge 20 -> idle in cycle 21
      dst = 3'd3; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      for (int c = 1; c <= LAST + 3; c++) begin
         chk($sformatf("abort_c%0d", c), obs, (c <= 20) ? exp_vec(c, 3'd3) : 21'h0);
         abort = (c == 20);
         @(posedge CLK); #1;
      end
      abort = 1'b0;
      run_op("post_abort", 3'd0, 1'b0);

      // asynchronous reset in cycle 30
      dst = 3'd6; start = 1'b1;
      @(posedge CLK); #1;
      start = 1'b0;
      for (int c = 1; c < 30; c++) begin
         @(posedge CLK); #1;
      end
      chk("pre_rst_c30", obs, exp_vec(30, 3'd6));
      CLR = 1'b0;
      #1;
      chk("rst_async", obs, '0);
      @(posedge CLK); #1;
      chk("rst_held", obs, '0);
      #2 CLR = 1'b1;
      run_op("post_rst", 3'd6, 1'b0);

      run_op("busy_start", 3'd1, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/h6_mul_sequencer.md
H6_MUL_SEQUENCER -- requirements
Module: h6_mul_sequencer

Interface
REQ-001 SHALL have parameter N_ITER, default 16, meaning the number of multiplier bit iterations per operation.
REQ-002 SHALL have port CLK  input  1  system clock; all state changes occur on the rising edge.
REQ-003 SHALL have port CLR  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin a multiply; sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  cancels any operation in progress.
REQ-006 SHALL have port dst  input  3  destination index: Q result goes to R[dst], A result goes to R[(dst+1) mod 8].
REQ-007 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse on completion.
REQ-009 SHALL have port err  output  1  one-cycle pulse on a rejected start.
REQ-010 SHALL have ports Rst_H6, MUL1, MUL2_1, MUL2_2, inQLK, inTWO, inTHREE, inFOUR, ALS_H6_a, ALS_H6_q  output  1 each  H6 control strobes.
REQ-011 SHALL have port SR  output  8  one-hot register write enables SR0..SR7 (bit i = SRi).

Function
REQ-012 SHALL implement states IDLE, CLEAR, LOAD, STEP2, STEP3, STEP4, WB_Q, WB_A, DONE.
REQ-013 SHALL decode every output combinationally from the state register only (Moore); in any state, an output not listed for that state is 0.
REQ-014 IDLE: if start=1, abort=0, and dst not in {4,5}, SHALL latch dst and go to CLEAR.
REQ-015 IDLE: if start=1, abort=0, and dst is 4 or 5 (the write would hit R5/PSW), SHALL stay in IDLE and drive err=1 in the next cycle only.
REQ-016 CLEAR: one cycle, Rst_H6=1, iteration counter cleared to 0; next state LOAD.
REQ-017 LOAD: one cycle, MUL1=1, MUL2_1=1, inQLK=1; next state STEP2.
REQ-018 Each iteration SHALL be STEP2 (inTWO=1) -> STEP3 (inTHREE=1) -> STEP4 (inFOUR=1), one cycle each.
REQ-019 STEP4 SHALL increment the counter; if the pre-increment count equals N_ITER-1, next state is WB_Q, otherwise STEP2.
REQ-020 The counter SHALL be ceil(log2(N_ITER))+1 bits wide and SHALL never wrap during an operation.
REQ-021 WB_Q: one cycle, ALS_H6_q=1, SR[dst_latched]=1.
REQ-022 WB_A: one cycle, ALS_H6_a=1, SR[(dst_latched+1) mod 8]=1; dst=7 writes R0.
REQ-023 DONE: one cycle, done=1; next state IDLE.
REQ-024 Latency: with start sampled at edge 0, done SHALL be high in cycle 3*N_ITER+5 (cycle 53 for N_ITER=16); busy SHALL be high from cycle 1 through the DONE cycle.
REQ-025 abort=1 in any non-IDLE state SHALL force IDLE at the next edge, with no WB strobes, no done, and no err.
REQ-026 abort=1 together with start=1 in IDLE: abort SHALL win; state stays IDLE and no err is produced.
REQ-027 start while busy SHALL be ignored and not queued.
REQ-028 Changes on dst after acceptance SHALL have no effect on the operation in progress.
REQ-029 SR SHALL never have more than one bit set, and MUL2_2 SHALL remain 0 in all states.

Reset
REQ-030 CLR=0 SHALL asynchronously force state IDLE, counter 0, dst_latched 0, and every output (busy, done, err, all strobes, SR) to 0.
REQ-031 CLR=0 asserted mid-operation SHALL discard the operation; after release, the block SHALL wait in IDLE for a new start.
REQ-032 After CLR rises, the first start SHALL be accepted at the first following rising edge.

Verification
REQ-033 Basic run: start=1, dst=2 for one cycle -> Rst_H6 in cycle 1, LOAD in cycle 2, 16 inTWO/inTHREE/inFOUR triplets, SR=0x04 with ALS_H6_q in cycle 51, SR=0x08 with ALS_H6_a in cycle 52, done in cycle 53.
REQ-034 Wrap: dst=7 -> SR=0x80 in WB_Q, then SR=0x01 in WB_A.
REQ-035 Reject: start with dst=4, and again with dst=5 -> err high one cycle each time, busy stays 0, no strobes.
REQ-036 Abort: abort=1 in cycle 20 -> IDLE in cycle 21, SR stays 0x00, done never asserted; a new start then completes normally.
REQ-037 Reset mid-op: CLR=0 in cycle 30 -> all outputs 0 immediately without waiting for a clock edge; start after release -> full 53-cycle sequence.
REQ-038 Busy start: extra start pulses during cycles 5-50 -> exactly one done pulse, in cycle 53.
